// File: rtl/i2s_dac_tx_pkg.sv
// Shared constants and helpers for the audio output path.
// utils carries clogb2 for counter sizing; synth_pkg carries the audio sample type and I2S frame geometry.
package utils;
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction
endpackage

package synth_pkg;
    localparam int AUDIO_DATA_W   = 24;
    localparam int I2S_SLOT_W     = 32;
    localparam int I2S_BCK_DIV    = 3;
    localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_W;

    typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;
endpackage

// File: rtl/i2s_dac_tx_if.sv
// Stereo sample hand-off from the synth engine to the I2S transmitter.
// A pair moves on a rising edge where sample_valid is high and either sample_ready was high
// or that edge starts a frame (the cycle after it shows frame_tick); the source holds data stable until then.
interface i2s_dac_tx_if #(
    parameter int DATA_W = synth_pkg::AUDIO_DATA_W
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_dac_tx_clkgen.sv
// Bit/word clock generator: divides AUDIO_CLK into BCK, tracks the frame bit position and LRCK.
// I2S_LEFT_JUSTIFIED_EN inverts LRCK polarity (1 = left) and its reset value.
module i2s_clkgen
    import synth_pkg::*;
#(
    parameter int SLOT_W  = I2S_SLOT_W,
    parameter int BCK_DIV = I2S_BCK_DIV,
    parameter int BIT_W   = utils::clogb2(2 * I2S_SLOT_W)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bck,
    output logic             lrck,
    output logic             bck_fall,
    output logic             frame_start,
    output logic             slot_right,
    output logic [BIT_W-1:0] slot_pos
);
    localparam int DIV_W = (BCK_DIV > 1) ? utils::clogb2(BCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_W);
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic LRCK_RST = 1'b0;
`else
    localparam logic LRCK_RST = 1'b1;
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bck_q, bck_d;
    logic             lrck_q, lrck_d;
    logic             div_tc;

    always_comb begin
        div_tc    = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
        bck_d     = div_tc ? ~bck_q : bck_q;
        bck_fall  = div_tc && bck_q;
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        if (bck_fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        // Position fields describe the bit that goes out after this falling edge.
        slot_right  = (bit_cnt_d >= SLOT);
        slot_pos    = slot_right ? bit_cnt_d - SLOT : bit_cnt_d;
        frame_start = bck_fall && (bit_cnt_d == '0);
        if (bck_fall) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
            lrck_d = ~slot_right;
`else
            lrck_d = slot_right;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= BIT_LAST;
            bck_q     <= 1'b0;
            lrck_q    <= LRCK_RST;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bck_q     <= bck_d;
            lrck_q    <= lrck_d;
        end
    end

    assign bck  = bck_q;
    assign lrck = lrck_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-deep hold register, per-frame shifters, underrun and frame-tick flags.
// I2S_LEFT_JUSTIFIED_EN selects left-justified framing (MSB in slot bit 0) instead of standard I2S.
module i2s_dac_tx
    import synth_pkg::*;
#(
    parameter int DATA_W  = AUDIO_DATA_W,
    parameter int SLOT_W  = I2S_SLOT_W,
    parameter int BCK_DIV = I2S_BCK_DIV
) (
    input  logic        AUDIO_CLK,
    input  logic        iRST,
    i2s_dac_tx_if.slave smp,
    output logic        frame_tick,
    output logic        underrun,
    output logic        AUD_BCK,
    output logic        AUD_LRCK,
    output logic        AUD_DATA
);
    localparam int BIT_W = utils::clogb2(2 * SLOT_W);
    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

    logic             bck_fall, frame_start, slot_right;
    logic [BIT_W-1:0] slot_pos;

    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic              hold_full_q, hold_full_d;
    logic              ready_q, ready_d;
    logic              data_q, data_d;
    logic              tick_q, tick_d;
    logic              underrun_q, underrun_d;
    logic              accept;
    logic [DATA_W-1:0] word, mask;
    int                pos;

    i2s_clkgen #(
        .SLOT_W (SLOT_W),
        .BCK_DIV(BCK_DIV),
        .BIT_W  (BIT_W)
    ) u_clkgen (
        .clk        (AUDIO_CLK),
        .rst        (iRST),
        .bck        (AUD_BCK),
        .lrck       (AUD_LRCK),
        .bck_fall   (bck_fall),
        .frame_start(frame_start),
        .slot_right (slot_right),
        .slot_pos   (slot_pos)
    );

    always_comb begin
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        data_d      = data_q;
        tick_d      = 1'b0;
        underrun_d  = 1'b0;
        word        = '0;
        mask        = '0;
        pos         = int'(slot_pos);

        // A frame start frees the hold register, so a waiting pair is taken on the same edge.
        accept = smp.sample_valid && (ready_q || frame_start);

        if (frame_start) begin
            tick_d      = 1'b1;
            hold_full_d = 1'b0;
            if (hold_full_q) begin
                shift_l_d = hold_l_q;
                shift_r_d = hold_r_q;
            end else begin
                shift_l_d  = '0;
                shift_r_d  = '0;
                underrun_d = 1'b1;
            end
        end
        if (accept) begin
            hold_l_d    = smp.sample_l;
            hold_r_d    = smp.sample_r;
            hold_full_d = 1'b1;
        end
        ready_d = ~hold_full_d;

        if (bck_fall) begin
            word = slot_right ? shift_r_d : shift_l_d;
`ifdef I2S_LEFT_JUSTIFIED_EN
            mask   = MSB_ONE >> pos;
            data_d = (pos < DATA_W) ? |(word & mask) : 1'b0;
`else
            mask   = MSB_ONE >> (pos - 1);
            data_d = (pos >= 1 && pos <= DATA_W) ? |(word & mask) : 1'b0;
`endif
        end
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (iRST) begin
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            data_q      <= 1'b0;
            tick_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            data_q      <= data_d;
            tick_q      <= tick_d;
            underrun_q  <= underrun_d;
        end
    end

    assign smp.sample_ready = ready_q;
    assign frame_tick       = tick_q;
    assign underrun         = underrun_q;
    assign AUD_DATA         = data_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: cycle-level pin model derived from elapsed time since reset, plus
// literal serial-frame expectations. Honours I2S_LEFT_JUSTIFIED_EN like the design.
module tb_i2s_dac_tx;
    localparam int DATA_W     = 24;
    localparam int SLOT_W     = 32;
    localparam int BCK_DIV    = 3;
    localparam int BCK_P      = 2 * BCK_DIV;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int FRAME_CYC  = BCK_P * FRAME_BITS;

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [63:0] LIT_T2 = 64'h80000100_7FFFFE00;
    localparam logic [63:0] LIT_A  = 64'h12345600_ABCDEF00;
    localparam logic [63:0] LIT_B  = 64'h00000100_FFFFFF00;
    localparam logic [63:0] LIT_C  = 64'hFFFFFF00_00000000;
    localparam logic        LRCK_RST = 1'b0;
`else
    localparam logic [63:0] LIT_T2 = 64'h40000080_3FFFFF00;
    localparam logic [63:0] LIT_A  = 64'h091A2B00_55E6F780;
    localparam logic [63:0] LIT_B  = 64'h00000080_7FFFFF80;
    localparam logic [63:0] LIT_C  = 64'h7FFFFF80_00000000;
    localparam logic        LRCK_RST = 1'b1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_dac_tx_if #(.DATA_W(DATA_W)) smp();
    logic frame_tick, underrun, aud_bck, aud_lrck, aud_data;

    i2s_dac_tx #(
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W),
        .BCK_DIV(BCK_DIV)
    ) dut (
        .AUDIO_CLK (clk),
        .iRST      (rst),
        .smp       (smp),
        .frame_tick(frame_tick),
        .underrun  (underrun),
        .AUD_BCK   (aud_bck),
        .AUD_LRCK  (aud_lrck),
        .AUD_DATA  (aud_data)
    );

    // model state
    int                  t = 0;
    int                  acc_cnt = 0;
    int                  checks = 0;
    int                  errors = 0;
    bit                  chk_en = 0;
    bit                  muted = 0;
    bit                  m_rdy, m_fs;
    logic [2*DATA_W-1:0] exp_q[$];
    logic [2*DATA_W-1:0] pr;
    logic [DATA_W-1:0]   cur_l = '0, cur_r = '0, w, wsh;
    logic [63:0]         shreg = '0, last_cap = '0;
    int                  n, b, p;
    logic                e_bck, e_lrck, e_data, e_tick, e_und, e_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // model: elapsed edges, hold contents and what each frame carries
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            exp_q.delete();
            cur_l = '0;
            cur_r = '0;
            muted = 0;
            chk_en = 1;
        end else begin
            t = t + 1;
            m_fs  = (t % FRAME_CYC) == BCK_P;
            m_rdy = (exp_q.size() == 0);
            if (m_fs) begin
                if (exp_q.size() != 0) begin
                    pr = exp_q.pop_front();
                    cur_l = pr[2*DATA_W-1:DATA_W];
                    cur_r = pr[DATA_W-1:0];
                    muted = 0;
                end else begin
                    cur_l = '0;
                    cur_r = '0;
                    muted = 1;
                end
            end
            if (smp.sample_valid && (m_rdy || m_fs)) begin
                exp_q.push_back({smp.sample_l, smp.sample_r});
                acc_cnt++;
            end
        end
    end

    // compare every cycle, plus capture of each completed serial frame
    always @(negedge clk) begin
        if (chk_en) begin
            n = t / BCK_P;
            b = (n == 0) ? FRAME_BITS - 1 : (n - 1) % FRAME_BITS;
            p = b % SLOT_W;
            w = (b < SLOT_W) ? cur_l : cur_r;
            e_bck = ((t / BCK_DIV) % 2) == 1;
`ifdef I2S_LEFT_JUSTIFIED_EN
            e_lrck = (b < SLOT_W);
            wsh = w >> (DATA_W - 1 - p);
            e_data = (n > 0 && p < DATA_W) ? wsh[0] : 1'b0;
`else
            e_lrck = (b >= SLOT_W);
            wsh = w >> (DATA_W - p);
            e_data = (n > 0 && p >= 1 && p <= DATA_W) ? wsh[0] : 1'b0;
`endif
            e_tick = (t >= BCK_P) && ((t - BCK_P) % FRAME_CYC == 0);
            e_und  = e_tick && muted;
            e_rdy  = (exp_q.size() == 0);
            check("bck", aud_bck, e_bck);
            check("lrck", aud_lrck, e_lrck);
            check("data", aud_data, e_data);
            check("frame_tick", frame_tick, e_tick);
            check("underrun", underrun, e_und);
            check("ready", smp.sample_ready, e_rdy);
            if (!rst && n > 0 && (t % BCK_P) == BCK_DIV) begin
                shreg[FRAME_BITS-1-b] = aud_data;
                if (b == FRAME_BITS - 1) last_cap = shreg;
            end
        end
    end

    // driver tasks
    task automatic offer(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int start;
        bit done;
        start = acc_cnt;
        done = 0;
        smp.sample_l = l;
        smp.sample_r = r;
        smp.sample_valid = 1'b1;
        for (int k = 0; k < FRAME_CYC + 10 && !done; k++) begin
            @(negedge clk);
            if (acc_cnt != start) done = 1;
        end
        smp.sample_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout t=%0d got no acceptance expected acceptance", t);
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 0;
        for (int k = 0; k < FRAME_CYC + 10 && !seen; k++) begin
            @(negedge clk);
            if (frame_tick) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout t=%0d got no frame_tick expected one", t);
        end
    endtask

    task automatic align(input int phase);
        for (int k = 0; k < FRAME_CYC + 2 && (t % FRAME_CYC) != phase; k++) @(negedge clk);
        if ((t % FRAME_CYC) != phase) begin
            checks++;
            errors++;
            $display("FAIL align t=%0d got phase %0d expected %0d", t, t % FRAME_CYC, phase);
        end
    endtask

    initial begin
        int first, und_cnt, cnt;
        smp.sample_valid = 1'b0;
        smp.sample_l = '0;
        smp.sample_r = '0;
        repeat (3) @(negedge clk);
        check("reset_lrck", aud_lrck, LRCK_RST);
        check("reset_ready", smp.sample_ready, 1'b1);
        rst = 1'b0;

        // idle: first tick at cycle 6, one muted frame per 384 cycles
        first = -1;
        und_cnt = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (frame_tick && first < 0) first = i;
            if (underrun) und_cnt++;
        end
        check("first_tick_cycle", first, 6);
        check("idle_underruns", und_cnt, 3);

        // single pair
        offer(24'h800001, 24'h7FFFFE);
        wait_tick();
        check("t2_no_underrun", underrun, 1'b0);
        repeat (FRAME_CYC - 1) @(negedge clk);
        check("t2_frame", last_cap, LIT_T2);

        // back-pressure: second pair waits for the frame start
        repeat (10) @(negedge clk);
        offer(24'h123456, 24'hABCDEF);
        check("t3_ready_low", smp.sample_ready, 1'b0);
        offer(24'h000001, 24'hFFFFFF);
        check("t3_b_on_tick", frame_tick, 1'b1);
        check("t3_a_no_underrun", underrun, 1'b0);
        check("t3_still_full", smp.sample_ready, 1'b0);
        repeat (FRAME_CYC - 1) @(negedge clk);
        check("t3_frame_a", last_cap, LIT_A);
        wait_tick();
        check("t3_b_no_underrun", underrun, 1'b0);
        repeat (FRAME_CYC - 1) @(negedge clk);
        check("t3_frame_b", last_cap, LIT_B);

        // valid coincident with a frame start while hold empty
        align(BCK_P - 1);
        smp.sample_l = 24'hFFFFFF;
        smp.sample_r = 24'h000000;
        smp.sample_valid = 1'b1;
        @(negedge clk);
        smp.sample_valid = 1'b0;
        check("t4_underrun", underrun, 1'b1);
        check("t4_tick", frame_tick, 1'b1);
        check("t4_hold_full", smp.sample_ready, 1'b0);
        wait_tick();
        check("t4_no_underrun", underrun, 1'b0);
        repeat (FRAME_CYC - 1) @(negedge clk);
        check("t4_frame_c", last_cap, LIT_C);

        // reset at bit 10 of the right slot
        repeat (10) @(negedge clk);
        offer(24'h555555, 24'hFFFFFF);
        wait_tick();
        align(BCK_P * (SLOT_W + 11) + 2);
        check("t5_pre_data", aud_data, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_bck", aud_bck, 1'b0);
        check("t5_rst_lrck", aud_lrck, LRCK_RST);
        check("t5_rst_data", aud_data, 1'b0);
        check("t5_rst_ready", smp.sample_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                first = i;
                check("t5_restart_underrun", underrun, 1'b1);
            end
        end
        check("t5_first_tick", first, 6);
        repeat (50) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
